// File: rtl/maxpool_seq_pkg.sv
// Shared constants and types for the pooling-stage max sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package maxpool_seq_pkg;

    // Pooling window sizes in elements.
    localparam int POOL_2X2   = 4;
    localparam int POOL_3X3   = 9;

    // Default element width in bits.
    localparam int N_DATA_DEF = 32;

    // Sequencer state. ST_OUT is exactly "result pending" (m_valid).
    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_e;

endpackage

// File: rtl/maxpool_seq_max2in.sv
// Two-input unsigned maximum; ties select ip2 (the newer element).
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state and no handshake.
module max2in #(
    parameter int N_DATA = 32
) (
    input  logic [N_DATA-1:0] ip1,
    input  logic [N_DATA-1:0] ip2,
    output logic [N_DATA-1:0] op
);

    // Greater-or-equal so that equal inputs pick ip2.
    always_comb begin
        op = (ip2 >= ip1) ? ip2 : ip1;
    end

endmodule

// File: rtl/maxpool_seq.sv
// Folds WIN_LEN streamed elements through one shared max2in and emits the window maximum.
// Latency: m_valid rises the cycle after the last element of a window is accepted.
// Backpressure: s_ready = !m_valid || m_ready; input stalls only while a result waits.
module maxpool_seq
    import maxpool_seq_pkg::*;
#(
    parameter int N_DATA  = N_DATA_DEF,
    parameter int WIN_LEN = POOL_2X2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [N_DATA-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [N_DATA-1:0] m_data,
    output logic              busy
);

    localparam int            CW       = $clog2(WIN_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIN_LEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_DATA-1:0]   acc_q, acc_d;
    logic [N_DATA-1:0]   m_data_q, m_data_d;
    logic [N_DATA-1:0]   max_res;
    logic                in_fire;
    logic                out_fire;

    // Single shared comparator: running max against the incoming element.
    max2in #(.N_DATA(N_DATA)) u_max2in (
        .ip1 (acc_q),
        .ip2 (s_data),
        .op  (max_res)
    );

    assign m_valid  = (state_q == ST_OUT);
    assign m_data   = m_data_q;
    assign s_ready  = !m_valid || m_ready;
    assign busy     = (cnt_q != '0) || m_valid;
    assign in_fire  = s_valid && s_ready;
    assign out_fire = m_valid && m_ready;

    // Next-state: retire the pending result, then fold the accepted element.
    // A last-element accept is applied after the retire so it re-enters ST_OUT.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        m_data_d = m_data_q;

        if (out_fire) begin
            state_d = ST_ACC;
        end

        if (in_fire) begin
            if (cnt_q == '0) begin
                // First element seeds the accumulator; comparator output unused.
                acc_d = s_data;
                cnt_d = CNT_ONE;
            end else if (cnt_q == CNT_LAST) begin
                // Last element goes straight to the output register.
                m_data_d = max_res;
                state_d  = ST_OUT;
                cnt_d    = '0;
            end else begin
                acc_d = max_res;
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // State registers; rst and clr both discard everything, including a pending result.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q  <= ST_ACC;
            cnt_q    <= '0;
            acc_q    <= '0;
            m_data_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            m_data_q <= m_data_d;
        end
    end

endmodule

// File: tb/tb_maxpool_seq.sv
// Self-checking bench for maxpool_seq: directed windows, corner sequences, randomized scoreboard.
// Latency: checks m_valid exactly one cycle after the last accepted element.
// Backpressure: exercises m_ready stalls directly and randomly.
module tb_maxpool_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;

    logic        s_valid4, s_ready4, m_valid4, m_ready4, busy4;
    logic [31:0] s_data4, m_data4;
    logic        s_valid2, s_ready2, m_valid2, m_ready2, busy2;
    logic [31:0] s_data2, m_data2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    maxpool_seq #(.N_DATA(32), .WIN_LEN(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .s_valid (s_valid4),
        .s_ready (s_ready4),
        .s_data  (s_data4),
        .m_valid (m_valid4),
        .m_ready (m_ready4),
        .m_data  (m_data4),
        .busy    (busy4)
    );

    maxpool_seq #(.N_DATA(32), .WIN_LEN(2)) dut2 (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .s_valid (s_valid2),
        .s_ready (s_ready2),
        .s_data  (s_data2),
        .m_valid (m_valid2),
        .m_ready (m_ready2),
        .m_data  (m_data2),
        .busy    (busy2)
    );

    typedef struct {
        logic [31:0] d [4];
        logic [31:0] exp_max;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    // Advance one clock; returns just after the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] max_of(input logic [31:0] q [$]);
        logic [31:0] m;
        m = 32'd0;
        foreach (q[i]) if (q[i] > m) m = q[i];
        return m;
    endfunction

    function automatic logic [31:0] rnd_data();
        int sel;
        sel = int'($urandom_range(0, 3));
        case (sel)
            0:       return 32'($urandom_range(0, 7));
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000 - 32'($urandom_range(0, 1));
            default: return $urandom;
        endcase
    endfunction

    vec_t        vecs [6];
    logic [31:0] win [$];
    logic [31:0] expq [$];
    logic [31:0] pair_d [3][2];
    logic [31:0] held;
    logic        was_stalled;

    initial begin
        rst = 1'b1; clr = 1'b0;
        s_valid4 = 1'b0; s_data4 = '0; m_ready4 = 1'b1;
        s_valid2 = 1'b0; s_data2 = '0; m_ready2 = 1'b1;

        // ---------------- reset values ----------------
        tick(); tick();
        chk("rst_m_valid", {31'd0, m_valid4}, 32'd0);
        chk("rst_m_data",  m_data4, 32'd0);
        chk("rst_busy",    {31'd0, busy4},    32'd0);
        chk("rst_s_ready", {31'd0, s_ready4}, 32'd1);
        rst = 1'b0;
        tick();

        // ---------------- table: back-to-back windows ----------------
        vecs[0] = '{d: '{32'd5, 32'd17, 32'd3, 32'd9},                                exp_max: 32'd17};
        vecs[1] = '{d: '{32'd1, 32'd2, 32'd3, 32'd4},                                 exp_max: 32'd4};
        vecs[2] = '{d: '{32'd40, 32'd30, 32'd20, 32'd10},                             exp_max: 32'd40};
        vecs[3] = '{d: '{32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0},         exp_max: 32'h8000_0000};
        vecs[4] = '{d: '{32'd7, 32'd7, 32'd0, 32'hFFFF_FFFF},                         exp_max: 32'hFFFF_FFFF};
        vecs[5] = '{d: '{32'd0, 32'd0, 32'd0, 32'd0},                                 exp_max: 32'd0};
        m_ready4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            for (int e = 0; e < 4; e++) begin
                s_valid4 = 1'b1; s_data4 = vecs[i].d[e];
                #1;
                chk($sformatf("tbl%0d_s_ready%0d", i, e), {31'd0, s_ready4}, 32'd1);
                tick();
                if (e == 3) begin
                    chk($sformatf("tbl%0d_m_valid", i), {31'd0, m_valid4}, 32'd1);
                    chk($sformatf("tbl%0d_m_data", i),  m_data4, vecs[i].exp_max);
                end else begin
                    chk($sformatf("tbl%0d_nv%0d", i, e),   {31'd0, m_valid4}, 32'd0);
                    chk($sformatf("tbl%0d_busy%0d", i, e), {31'd0, busy4},    32'd1);
                end
            end
        end
        s_valid4 = 1'b0;
        tick();
        chk("tbl_drain_m_valid", {31'd0, m_valid4}, 32'd0);
        chk("tbl_drain_busy",    {31'd0, busy4},    32'd0);

        // ---------------- backpressure ----------------
        m_ready4 = 1'b0;
        for (int e = 0; e < 4; e++) begin
            s_valid4 = 1'b1; s_data4 = vecs[4].d[e];
            tick();
        end
        s_data4 = 32'd2;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp_s_ready_low%0d", k), {31'd0, s_ready4}, 32'd0);
            chk($sformatf("bp_m_valid%0d", k),     {31'd0, m_valid4}, 32'd1);
            chk($sformatf("bp_m_data_hold%0d", k), m_data4, 32'hFFFF_FFFF);
            tick();
        end
        m_ready4 = 1'b1;
        #1;
        chk("bp_s_ready_rise", {31'd0, s_ready4}, 32'd1);
        tick();
        chk("bp_taken_m_valid", {31'd0, m_valid4}, 32'd0);
        chk("bp_first_busy",    {31'd0, busy4},    32'd1);
        s_data4 = 32'd3; tick();
        s_data4 = 32'd1; tick();
        s_data4 = 32'd0; tick();
        chk("bp_next_m_valid", {31'd0, m_valid4}, 32'd1);
        chk("bp_next_m_data",  m_data4, 32'd3);
        s_valid4 = 1'b0;
        tick();

        // ---------------- clear mid-window ----------------
        s_valid4 = 1'b1; s_data4 = 32'd50; tick();
        s_data4 = 32'd60; tick();
        chk("clr_busy_before", {31'd0, busy4}, 32'd1);
        clr = 1'b1; s_data4 = 32'd99;
        #1;
        chk("clr_busy_during", {31'd0, busy4}, 32'd1);
        tick();
        clr = 1'b0; s_valid4 = 1'b0;
        chk("clr_busy_after",  {31'd0, busy4},   32'd0);
        chk("clr_m_valid",     {31'd0, m_valid4}, 32'd0);
        for (int e = 0; e < 4; e++) begin
            s_valid4 = 1'b1; s_data4 = 32'(e + 1);
            tick();
        end
        s_valid4 = 1'b0;
        chk("clr_res_m_valid", {31'd0, m_valid4}, 32'd1);
        chk("clr_res_m_data",  m_data4, 32'd4);
        tick();
        chk("clr_single_result", {31'd0, m_valid4}, 32'd0);

        // ---------------- clear drops a pending result ----------------
        m_ready4 = 1'b0;
        for (int e = 0; e < 4; e++) begin
            s_valid4 = 1'b1; s_data4 = 32'(10 + e);
            tick();
        end
        s_valid4 = 1'b0;
        chk("drop_pending_m_valid", {31'd0, m_valid4}, 32'd1);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("drop_m_valid", {31'd0, m_valid4}, 32'd0);
        chk("drop_m_data",  m_data4, 32'd0);
        m_ready4 = 1'b1;

        // ---------------- WIN_LEN=2: idle gap ----------------
        s_valid2 = 1'b1; s_data2 = 32'd9; tick();
        s_valid2 = 1'b0; s_data2 = 32'd500;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("gap_busy%0d", k),    {31'd0, busy2},    32'd1);
            chk($sformatf("gap_m_valid%0d", k), {31'd0, m_valid2}, 32'd0);
        end
        s_valid2 = 1'b1; s_data2 = 32'd11; tick();
        chk("gap_m_valid", {31'd0, m_valid2}, 32'd1);
        chk("gap_m_data",  m_data2, 32'd11);

        // ---------------- WIN_LEN=2: throughput ----------------
        pair_d[0][0] = 32'd3;   pair_d[0][1] = 32'd8;
        pair_d[1][0] = 32'd200; pair_d[1][1] = 32'd100;
        pair_d[2][0] = 32'd5;   pair_d[2][1] = 32'd5;
        for (int p = 0; p < 3; p++) begin
            for (int e = 0; e < 2; e++) begin
                s_data2 = pair_d[p][e];
                #1;
                chk($sformatf("w2_s_ready%0d_%0d", p, e), {31'd0, s_ready2}, 32'd1);
                tick();
                chk($sformatf("w2_m_valid%0d_%0d", p, e), {31'd0, m_valid2}, (e == 1) ? 32'd1 : 32'd0);
                if (e == 1)
                    chk($sformatf("w2_m_data%0d", p), m_data2,
                        (pair_d[p][0] > pair_d[p][1]) ? pair_d[p][0] : pair_d[p][1]);
            end
        end
        s_valid2 = 1'b0;
        tick();

        // ---------------- randomized against window scoreboard ----------------
        rst = 1'b1; tick(); rst = 1'b0;
        win.delete(); expq.delete();
        was_stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s_valid4 = ($urandom_range(0, 3) != 0);
            s_data4  = rnd_data();
            m_ready4 = ($urandom_range(0, 2) != 0);
            #1;
            chk("rnd_m_valid", {31'd0, m_valid4}, (expq.size() != 0) ? 32'd1 : 32'd0);
            chk("rnd_busy",    {31'd0, busy4},
                ((win.size() != 0) || (expq.size() != 0)) ? 32'd1 : 32'd0);
            chk("rnd_s_ready", {31'd0, s_ready4}, (expq.size() == 0 || m_ready4) ? 32'd1 : 32'd0);
            if (was_stalled)
                chk("rnd_hold", m_data4, held);
            if (expq.size() != 0 && m_ready4) begin
                chk("rnd_m_data", m_data4, expq.pop_front());
            end
            was_stalled = (expq.size() != 0) && !m_ready4;
            held = m_data4;
            if (s_valid4 && (expq.size() == 0 || m_ready4)) begin
                win.push_back(s_data4);
                if (win.size() == 4) begin
                    expq.push_back(max_of(win));
                    win.delete();
                end
            end
            @(posedge clk);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/maxpool_seq.md
# maxpool_seq

Sequencer for the shared `max2in` comparator in the pooling stage. It accepts a stream of `WIN_LEN` window elements over a valid/ready handshake and folds them one per cycle through a single `max2in` instance into a running-max register. It emits one pooled result per window on a valid/ready output. It sits between the convolution/activation output stream and the pooled feature-map writer.

## Interface
Parameters:
- `N_DATA`, default 32, element width in bits; comparison is unsigned.
- `WIN_LEN`, default 4, elements per pooling window (4 = 2x2, 9 = 3x3); legal range 2..256.

Ports:
- `clk`  in  1  single clock; every register is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `clr`  in  1  synchronous discard of the partial window; same effect as `rst`.
- `s_valid`  in  1  input element valid.
- `s_ready`  out  1  block can accept an element.
- `s_data`  in  N_DATA  input element.
- `m_valid`  out  1  pooled result valid.
- `m_ready`  in  1  downstream accepts the result.
- `m_data`  out  N_DATA  pooled maximum.
- `busy`  out  1  high when a partial window is held or a result is pending.

## Operation
- An input beat is accepted when `s_valid && s_ready`. An output beat completes when `m_valid && m_ready`.
- `cnt` is `$clog2(WIN_LEN)` bits wide and indexes the element within the window (0..WIN_LEN-1).
- Accept with `cnt == 0`: `acc <= s_data`, then `cnt <= 1`. The comparator result is ignored on this beat.
- Accept with `0 < cnt < WIN_LEN-1`: `acc <= max2in(acc, s_data)`, then `cnt <= cnt+1`.
- Accept with `cnt == WIN_LEN-1`:
  - `m_data <= max2in(acc, s_data)`, `m_valid <= 1`, `cnt <= 0`.
  - `acc` is not updated.
- Two states:
  - **ACC**: `m_valid = 0`.
  - **OUT**: `m_valid = 1`.
  - ACC goes to OUT on the last-element accept.
  - OUT goes to ACC on an output beat, unless that same cycle also accepts a last element, in which case the block stays in OUT with new `m_data`.
- `s_ready = !m_valid || m_ready`. Input stalls only while a result is pending and not taken.
  - Output beat plus first-element accept in the same cycle: the result leaves and `acc` loads `s_data`. No bubble.
  - The `WIN_LEN == 2` case also sustains one window per 2 cycles.
- Ties: `max2in` selects `ip2` (the new element) on equality. The output value is identical either way.
- `m_data` holds stable while `m_valid && !m_ready`.
- `busy = (cnt != 0) || m_valid`.
- `rst` or `clr` (priority over all other activity in that cycle):
  - `cnt = 0`, `acc = 0`, `m_valid = 0`, `m_data = 0`, state ACC.
  - A pending result is dropped.
  - An input beat presented in that cycle is not consumed. `s_ready` is still combinationally high, so upstream must also be cleared.

## Timing
- Reset values: `m_valid = 0`, `m_data = 0`, `busy = 0`, `s_ready = 1`.
- Latency: `m_valid` rises on the cycle after the last element is accepted.
- Throughput: one window per `WIN_LEN` cycles with `s_valid` and `m_ready` held high.
- The comparator path is a single combinational stage: `acc`/`s_data` → `max2in` → `acc`/`m_data`. No extra pipeline stages.
- `s_ready` depends combinationally on `m_ready`. Nothing else is combinational from input to output.
- Gaps in `s_valid` mid-window leave `cnt` and `acc` unchanged for any number of cycles.

## Structure
- Shared constants header:
  - pooling window sizes (`POOL_2X2 = 4`, `POOL_3X3 = 9`);
  - the default `N_DATA`.
- Exactly one sub-module: `max2in #(.N_DATA(N_DATA))`.
  - `ip1 = acc`, `ip2 = s_data`.
  - Its output is shared by the `acc` and `m_data` update paths.
- Control lives in the top module: `cnt`, the state bit (equivalent to `m_valid`), and the `acc`/`m_data` registers.

## Test plan
- **Basic window:** `WIN_LEN = 4`, stream 5, 17, 3, 9 with `m_ready = 1` → one `m_valid` pulse with `m_data = 17`, one cycle after the 9 is accepted.
- **Back-to-back windows:** stream 1, 2, 3, 4, then 40, 30, 20, 10, with `s_valid` continuous → results 4 then 40. `s_ready` never drops. Results arrive 4 cycles apart.
- **Backpressure:** hold `m_ready = 0` after the window 7, 7, 0, 0xFFFFFFFF → `m_data` holds 0xFFFFFFFF and `s_ready = 0`. Raise `m_ready` together with next element 2 → the result is taken and 2 is loaded as the first element of the next window.
- **Unsigned/tie rules:** window 0x80000000, 0x7FFFFFFF, 0x80000000, 0 → `m_data = 0x80000000`.
- **Clear mid-window:** accept 50, 60, assert `clr` for one cycle, then stream 1, 2, 3, 4 → single result 4. `busy` reads 1, 1, 0 around the `clr`.
- **Idle gaps / `WIN_LEN = 2`:** drop `s_valid` for 3 cycles between elements 9 and 11 → result 11. With `s_valid` and `m_ready` held high, results appear every 2 cycles.
